sigpulse_burst: RTL and testbench

Multi-channel, parametrised burst pulse generator; successor to the single-shot `sigpulse` block. Each of `_CH` independent channels:
- detects a rising edge on its enable;
- waits a programmable delay;
- emits a programmable number of pulses with programmable width and period, then signals completion.

It sits between the register/RAM configuration path and the I/O pins, replacing per-pin single-pulse instances.

---
 rtl/sigpulse_burst.sv | 205 ++++++++++++++++++++
 tb/tb_sigpulse_burst.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sigpulse_burst.sv
// sigpulse_burst: multi-channel burst pulse generator.
// Each channel waits for a rising edge on its enable, waits a programmable
// delay, then emits a programmable number of pulses with programmable width
// and period. A pulse count of 0 keeps the channel pulsing until it is aborted.
//
// Ports (channel i uses bit i, or the slice [i*W +: W] of a packed bus):
//   io_clk, io_rst      clock and synchronous active-high reset
//   io_en               per-channel start request (rising-edge detected)
//   io_abort            per-channel level abort back to IDLE
//   io_delay            cycles from start to first pulse
//   io_pulseWidth       active cycles per pulse (0 treated as 1)
//   io_period           pulse start-to-start cycles (at least width+1)
//   io_pulseCount       pulses per burst, 0 = continuous
//   io_defaultLevel     idle output level; the active level is its inverse
//   io_pulseOut         pulse output
//   pulse_valid         high while the output is at the active level
//   io_busy             high while the channel is not IDLE
//   io_done             one-cycle strobe when a counted burst completes

module sigpulse_burst_ch #(
    parameter int RAM_WIDTH = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 abort,
    input  logic [RAM_WIDTH-1:0] delay,
    input  logic [RAM_WIDTH-1:0] pulse_width,
    input  logic [RAM_WIDTH-1:0] period,
    input  logic [CNT_WIDTH-1:0] pulse_count,
    input  logic                 default_level,
    output logic                 pulse_out,
    output logic                 pulse_valid,
    output logic                 busy,
    output logic                 done
);
    typedef enum logic [1:0] {IDLE, DELAY, ACTIVE, GAP} state_t;

    localparam logic [RAM_WIDTH-1:0] ONE   = 1;
    localparam logic [RAM_WIDTH:0]   ONE_X = 1;
    localparam logic [CNT_WIDTH-1:0] C_ONE = 1;

    state_t               state, state_n;
    logic [RAM_WIDTH-1:0] cnt, cnt_n;
    logic [CNT_WIDTH-1:0] pc, pc_n;
    logic [RAM_WIDTH-1:0] we_q, pe_q;
    logic [CNT_WIDTH-1:0] n_q;
    logic                 lvl_q, act_q, done_q, en_d1;
    logic                 act_n, done_n, load, start;

    // Effective width/period computed from the live inputs; captured on start.
    logic [RAM_WIDTH-1:0] we_in, pe_in, gap, gap_load;
    logic [RAM_WIDTH:0]   we_p1;

    always_comb begin
        we_in = (pulse_width == '0) ? ONE : pulse_width;
        we_p1 = {1'b0, we_in} + ONE_X;
        // A carry out of we_in+1 means no legal period exists; saturate.
        if (we_p1[RAM_WIDTH])
            pe_in = '1;
        else if ({1'b0, period} > we_p1)
            pe_in = period;
        else
            pe_in = we_p1[RAM_WIDTH-1:0];
        gap      = pe_q - we_q;
        gap_load = (gap == '0) ? '0 : gap - ONE;
    end

    // en_d1 resets high so an enable held through reset is not an edge.
    assign start = en & ~en_d1 & (state == IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            pc     <= '0;
            we_q   <= '0;
            pe_q   <= '0;
            n_q    <= '0;
            lvl_q  <= 1'b0;
            act_q  <= 1'b0;
            done_q <= 1'b0;
            en_d1  <= 1'b1;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            pc     <= pc_n;
            act_q  <= act_n;
            done_q <= done_n;
            en_d1  <= en;
            if (state == IDLE)
                lvl_q <= default_level;
            if (load) begin
                we_q <= we_in;
                pe_q <= pe_in;
                n_q  <= pulse_count;
            end
        end
    end

    // Next-state logic. cnt holds remaining cycles minus one in the current
    // phase, so a phase of length L is left on the edge where cnt is zero.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pc_n    = pc;
        done_n  = 1'b0;
        load    = 1'b0;
        if (abort) begin
            state_n = IDLE;
            cnt_n   = '0;
            pc_n    = '0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    load = 1'b1;
                    pc_n = pulse_count;
                    if (delay == '0) begin
                        state_n = ACTIVE;
                        cnt_n   = we_in - ONE;
                    end else begin
                        state_n = DELAY;
                        cnt_n   = delay - ONE;
                    end
                end
                DELAY, GAP: begin
                    if (cnt == '0) begin
                        state_n = ACTIVE;
                        cnt_n   = we_q - ONE;
                    end else begin
                        cnt_n = cnt - ONE;
                    end
                end
                ACTIVE: begin
                    if (cnt != '0) begin
                        cnt_n = cnt - ONE;
                    end else if (n_q != '0 && pc == C_ONE) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                        pc_n    = '0;
                        done_n  = 1'b1;
                    end else begin
                        state_n = GAP;
                        cnt_n   = gap_load;
                        if (n_q != '0)
                            pc_n = pc - C_ONE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Outputs
    always_comb begin
        act_n       = (state_n == ACTIVE);
        pulse_out   = lvl_q ^ act_q;
        pulse_valid = act_q;
        busy        = (state != IDLE);
        done        = done_q;
    end
endmodule

module sigpulse_burst #(
    parameter int _RAM_WIDTH = 32,
    parameter int _CNT_WIDTH = 16,
    parameter int _CH        = 4
) (
    input  logic                       io_clk,
    input  logic                       io_rst,
    input  logic [_CH-1:0]             io_en,
    input  logic [_CH-1:0]             io_abort,
    input  logic [_CH*_RAM_WIDTH-1:0]  io_delay,
    input  logic [_CH*_RAM_WIDTH-1:0]  io_pulseWidth,
    input  logic [_CH*_RAM_WIDTH-1:0]  io_period,
    input  logic [_CH*_CNT_WIDTH-1:0]  io_pulseCount,
    input  logic [_CH-1:0]             io_defaultLevel,
    output logic [_CH-1:0]             io_pulseOut,
    output logic [_CH-1:0]             pulse_valid,
    output logic [_CH-1:0]             io_busy,
    output logic [_CH-1:0]             io_done
);
    for (genvar i = 0; i < _CH; i++) begin : g_ch
        sigpulse_burst_ch #(
            .RAM_WIDTH(_RAM_WIDTH),
            .CNT_WIDTH(_CNT_WIDTH)
        ) u_ch (
            .clk          (io_clk),
            .rst          (io_rst),
            .en           (io_en[i]),
            .abort        (io_abort[i]),
            .delay        (io_delay[i*_RAM_WIDTH +: _RAM_WIDTH]),
            .pulse_width  (io_pulseWidth[i*_RAM_WIDTH +: _RAM_WIDTH]),
            .period       (io_period[i*_RAM_WIDTH +: _RAM_WIDTH]),
            .pulse_count  (io_pulseCount[i*_CNT_WIDTH +: _CNT_WIDTH]),
            .default_level(io_defaultLevel[i]),
            .pulse_out    (io_pulseOut[i]),
            .pulse_valid  (pulse_valid[i]),
            .busy         (io_busy[i]),
            .done         (io_done[i])
        );
    end
endmodule

// File: tb/tb_sigpulse_burst.sv
// Directed bench for sigpulse_burst. Expected waveforms come from the
// closed-form timing: pulse j active at offsets D+j*Pe .. D+j*Pe+We-1 after
// the start edge, done at offset D+(N-1)*Pe+We, with We/Pe hand-computed.
module tb_sigpulse_burst;
    localparam int RW = 32;
    localparam int CW = 16;
    localparam int CH = 4;
    localparam int NS = 1000000000;  // "never started" start cycle

    logic             clk = 1'b0;
    logic             rst;
    logic [CH-1:0]    en, abort, dflt;
    logic [CH*RW-1:0] delay, width, period;
    logic [CH*CW-1:0] count;
    logic [CH-1:0]    pulse_out, valid, busy, done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int m_ks[CH], m_d[CH], m_we[CH], m_pe[CH], m_n[CH];

    sigpulse_burst #(._RAM_WIDTH(RW), ._CNT_WIDTH(CW), ._CH(CH)) dut (
        .io_clk(clk), .io_rst(rst), .io_en(en), .io_abort(abort),
        .io_delay(delay), .io_pulseWidth(width), .io_period(period),
        .io_pulseCount(count), .io_defaultLevel(dflt),
        .io_pulseOut(pulse_out), .pulse_valid(valid),
        .io_busy(busy), .io_done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0b want=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic f_act(input int o, input int d, input int we, input int pe, input int n);
        int r;
        if (o < d) return 1'b0;
        r = o - d;
        if (n != 0 && r / pe >= n) return 1'b0;
        return (r % pe) < we;
    endfunction

    function automatic logic f_busy(input int o, input int d, input int we, input int pe, input int n);
        return (o >= 0) && (n == 0 || o < d + (n - 1) * pe + we);
    endfunction

    function automatic logic f_done(input int o, input int d, input int we, input int pe, input int n);
        return (n != 0) && (o == d + (n - 1) * pe + we);
    endfunction

    task automatic set_cfg(input int c, input int d, input int w, input int p, input int n);
        delay[c*RW +: RW]  = d;
        width[c*RW +: RW]  = w;
        period[c*RW +: RW] = p;
        count[c*CW +: CW]  = CW'(n);
    endtask

    task automatic model(input int c, input int d, input int we, input int pe, input int n);
        m_ks[c] = cyc;
        m_d[c]  = d;
        m_we[c] = we;
        m_pe[c] = pe;
        m_n[c]  = n;
    endtask

    task automatic check_all();
        int   o;
        logic a;
        for (int c = 0; c < CH; c++) begin
            o = cyc - m_ks[c];
            a = f_act(o, m_d[c], m_we[c], m_pe[c], m_n[c]);
            chk1($sformatf("out%0d@%0d", c, cyc), pulse_out[c], dflt[c] ^ a);
            chk1($sformatf("valid%0d@%0d", c, cyc), valid[c], a);
            chk1($sformatf("busy%0d@%0d", c, cyc), busy[c],
                 f_busy(o, m_d[c], m_we[c], m_pe[c], m_n[c]));
            chk1($sformatf("done%0d@%0d", c, cyc), done[c],
                 f_done(o, m_d[c], m_we[c], m_pe[c], m_n[c]));
        end
    endtask

    initial begin
        for (int c = 0; c < CH; c++) begin
            m_ks[c] = NS; m_d[c] = 0; m_we[c] = 1; m_pe[c] = 2; m_n[c] = 0;
        end
        rst = 1'b1; en = '1; abort = '0; dflt = 4'b0101;
        delay = '0; width = '0; period = '0; count = '0;

        // Reset values, enable held high through reset
        repeat (3) tick();
        chk4("rst_out", pulse_out, 4'h0);
        chk4("rst_valid", valid, 4'h0);
        chk4("rst_busy", busy, 4'h0);
        chk4("rst_done", done, 4'h0);
        rst = 1'b0;
        chk4("rel_out0", pulse_out, 4'h0);
        tick();
        chk4("rel_out1", pulse_out, 4'b0101);
        chk4("held_en_busy", busy, 4'h0);
        repeat (2) begin tick(); check_all(); end
        en = '0;
        tick(); check_all();

        // Single shot: ch0 default 1, D=0 W=100 N=1 -> We=100 Pe=101
        set_cfg(0, 0, 100, 0, 1);
        en[0] = 1'b1;
        tick(); model(0, 0, 100, 101, 1);
        for (int i = 0; i <= 101; i++) begin
            check_all();
            if (i == 1) en[0] = 1'b0;
            tick();
        end
        check_all();

        // Burst: ch1 D=5 W=3 P=10 N=4, with retrigger and config change mid-burst
        set_cfg(1, 5, 3, 10, 4);
        en[1] = 1'b1;
        tick(); model(1, 5, 3, 10, 4);
        for (int o = 0; o <= 41; o++) begin
            check_all();
            if (o == 3)  en[1] = 1'b0;
            if (o == 7)  set_cfg(1, 0, 1, 2, 1);
            if (o == 12) en[1] = 1'b1;
            tick();
        end
        en[1] = 1'b0;
        tick(); check_all();

        // Clamping: ch2 W=0 -> We=1 Pe=2; D=2 N=3
        set_cfg(2, 2, 0, 0, 3);
        en[2] = 1'b1;
        tick(); model(2, 2, 1, 2, 3);
        for (int o = 0; o <= 9; o++) begin
            check_all();
            if (o == 1) en[2] = 1'b0;
            tick();
        end
        // Clamping: ch2 W=5 P=2 -> Pe=6; D=0 N=2
        set_cfg(2, 0, 5, 2, 2);
        en[2] = 1'b1;
        tick(); model(2, 0, 5, 6, 2);
        for (int o = 0; o <= 13; o++) begin
            check_all();
            if (o == 1) en[2] = 1'b0;
            tick();
        end

        // Continuous ch3 D=1 W=2 P=4 N=0, aborted mid-ACTIVE
        set_cfg(3, 1, 2, 4, 0);
        en[3] = 1'b1;
        tick(); model(3, 1, 2, 4, 0);
        for (int o = 0; o <= 12; o++) begin
            check_all();
            if (o == 1) en[3] = 1'b0;
            tick();
        end
        check_all();
        chk1("pre_abort_valid", valid[3], 1'b1);
        abort[3] = 1'b1;
        tick(); m_ks[3] = NS;
        check_all();
        abort[3] = 1'b0;
        tick(); check_all();

        // Abort and start in the same cycle on ch0
        set_cfg(0, 0, 4, 0, 1);
        en[0] = 1'b1; abort[0] = 1'b1;
        tick(); check_all();
        abort[0] = 1'b0;
        tick(); check_all();
        en[0] = 1'b0;
        tick(); check_all();

        // Multi-channel, staggered starts
        set_cfg(0, 3, 2, 5, 3);   // We=2 Pe=5
        set_cfg(1, 0, 4, 4, 2);   // We=4 Pe=5
        set_cfg(2, 7, 1, 3, 2);   // We=1 Pe=3
        set_cfg(3, 1, 3, 0, 0);   // We=3 Pe=4, continuous
        en[0] = 1'b1; tick(); model(0, 3, 2, 5, 3); check_all();
        tick(); check_all();
        en[1] = 1'b1; tick(); model(1, 0, 4, 5, 2); check_all();
        en[2] = 1'b1; tick(); model(2, 7, 1, 3, 2); check_all();
        en[3] = 1'b1; tick(); model(3, 1, 3, 4, 0); check_all();
        en = '0;
        for (int i = 0; i < 30; i++) begin tick(); check_all(); end
        // Stop the continuous channel before the reset segment
        abort[3] = 1'b1; tick(); m_ks[3] = NS; check_all();
        abort[3] = 1'b0; tick(); check_all();

        // All channels started together, then reset mid-burst
        en = '1;
        tick();
        model(0, 3, 2, 5, 3); model(1, 0, 4, 5, 2);
        model(2, 7, 1, 3, 2); model(3, 1, 3, 4, 0);
        for (int i = 0; i < 4; i++) begin check_all(); tick(); end
        chk4("mid_busy", busy, 4'hF);
        en = '0; rst = 1'b1;
        tick();
        chk4("mrst_out", pulse_out, 4'h0);
        chk4("mrst_valid", valid, 4'h0);
        chk4("mrst_busy", busy, 4'h0);
        chk4("mrst_done", done, 4'h0);
        rst = 1'b0;
        for (int c = 0; c < CH; c++) m_ks[c] = NS;
        chk4("mrel_out0", pulse_out, 4'h0);
        tick(); check_all();
        tick(); check_all();

        // Nominal start after reset: ch1 D=2 W=2 P=3 N=2 -> Pe=3
        set_cfg(1, 2, 2, 3, 2);
        en[1] = 1'b1;
        tick(); model(1, 2, 2, 3, 2);
        for (int o = 0; o <= 9; o++) begin
            check_all();
            if (o == 1) en[1] = 1'b0;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
